// File: rtl/regfile_writeback_if.sv
// Writer-side bus for the register file front end: ALU and LSU result inputs,
// issue/decode scoreboard queries, and the registered WE3/A3/WD3 write port.
interface regfile_writeback_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;

    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            busy1;
    logic            busy2;

    logic            WE3;
    logic [4:0]      A3;
    logic [XLEN-1:0] WD3;

    // Pipeline side: produces results and issue/decode queries.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd, rs1, rs2,
        input  lsu_ready, busy1, busy2,
        input  WE3, A3, WD3
    );

    // Write-back block side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd, rs1, rs2,
        output lsu_ready, busy1, busy2,
        output WE3, A3, WD3
    );
endinterface

// File: rtl/regfile_writeback.sv
// Arbitrates ALU and buffered LSU results onto the single register file write
// port and tracks which registers still await writeback.
module regfile_writeback #(
    parameter int XLEN      = 32,
    parameter int LSU_DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    regfile_writeback_if.slave bus
);
    localparam int            PW      = $clog2(LSU_DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(LSU_DEPTH);

    logic [4:0]      fifo_rd   [LSU_DEPTH];
    logic [XLEN-1:0] fifo_data [LSU_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [31:0]     pending;

    logic alu_take;
    logic pop;
    logic push;

    // An x0 ALU result is dropped and leaves the port free for the FIFO head.
    assign alu_take      = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign pop           = !alu_take && (count != '0);
    assign bus.lsu_ready = (count < DEPTH_C);
    assign push          = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != 5'd0);

    assign bus.busy1 = pending[bus.rs1];
    assign bus.busy2 = pending[bus.rs2];

    // NOTE: the storage array carries no reset; occupancy is defined solely by
    // count and the pointers, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= bus.lsu_rd;
            fifo_data[wr_ptr] <= bus.lsu_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.WE3 <= 1'b0;
            bus.A3  <= '0;
            bus.WD3 <= '0;
        end else if (alu_take) begin
            bus.WE3 <= 1'b1;
            bus.A3  <= bus.alu_rd;
            bus.WD3 <= bus.alu_data;
        end else if (pop) begin
            bus.WE3 <= 1'b1;
            bus.A3  <= fifo_rd[rd_ptr];
            bus.WD3 <= fifo_data[rd_ptr];
        end else begin
            bus.WE3 <= 1'b0;
        end
    end

    // The set is written last so a fresh producer wins over a same-edge clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (bus.WE3) pending[bus.A3] <= 1'b0;
            if (bus.issue_valid && (bus.issue_rd != 5'd0)) pending[bus.issue_rd] <= 1'b1;
            pending[0] <= 1'b0;
        end
    end
endmodule
